mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage RV32I pipeline. Consumes the `rv32i_stage` bundle held in the EX/MEM pipeline register, issues the data-memory read or write it describes, aligns store data and byte enables, and extracts and extends load data into `data_mdr`. It then registers the updated bundle into the MEM/WB register that feeds writeback. While a memory access is outstanding it stalls everything upstream.

## Interface
- No parameters. Widths come from `rv32i_types`.
- `clk`  in  1  pipeline clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ex_mem_i`  in  `rv32i_stage`  EX/MEM bundle. Held stable by upstream while `stall_o`=1.
- `ex_mem_valid_i`  in  1  `ex_mem_i` holds a real instruction. When 0 it is a bubble.
- `stall_o`  out  1  freeze PC, IF/ID, ID/EX and EX/MEM registers.
- `mem_wb_o`  out  `rv32i_stage`  registered MEM/WB bundle.
- `mem_wb_valid_o`  out  1  `mem_wb_o` is a real instruction.
- `dmem_read_o`  out  1  data-memory read request.
- `dmem_write_o`  out  1  data-memory write request.
- `dmem_address_o`  out  32  word-aligned address.
- `dmem_wdata_o`  out  32  lane-aligned store data.
- `dmem_mbe_o`  out  4  lane-aligned byte enable.
- `dmem_rdata_i`  in  32  read data. Valid when `dmem_resp_i`=1.
- `dmem_resp_i`  in  1  single-cycle completion pulse for the current request.

## Operation
- Terms used below:
  - is_mem = `ex_mem_valid_i` & (ControlWord.dmem_read | ControlWord.dmem_write).
  - off = DataWord.alu_out[1:0].
- FSM has two states: IDLE and ACCESS.
- IDLE, not is_mem:
  - Next edge: `mem_wb_o` <= `ex_mem_i` and `mem_wb_valid_o` <= `ex_mem_valid_i`.
  - Stay in IDLE.
- IDLE, is_mem:
  - Next edge: go to ACCESS and write a bubble (`mem_wb_valid_o` <= 0).
  - Registered request at that edge:
    - `dmem_address_o` <= {alu_out[31:2], 2'b00}.
    - `dmem_wdata_o` <= rs2_out << (8*off).
    - `dmem_mbe_o` <= mem_byte_enable << off, truncated to 4 bits.
    - `dmem_write_o` <= dmem_write.
    - `dmem_read_o` <= dmem_read & ~dmem_write. Write wins if both are set.
- ACCESS, `dmem_resp_i`=0:
  - Hold all request outputs.
  - Write a bubble to MEM/WB.
- ACCESS, `dmem_resp_i`=1, next edge:
  - Clear `dmem_read_o`, `dmem_write_o` and `dmem_mbe_o`.
  - Go to IDLE.
  - `mem_wb_o` <= `ex_mem_i`, with DataWord.data_mdr replaced by load data if this is a read.
  - `mem_wb_valid_o` <= 1.
- Load extraction from `dmem_rdata_i`, selected by ControlWord.funct3:
  - lb / lbu: byte at lane off, sign- or zero-extended to 32 bits.
  - lh / lhu: halfword at bits [16*off[1] +: 16], extended. off[0] is ignored.
  - lw: full word. off is ignored.
  - Other funct3 values: full word.
- Stores leave data_mdr unchanged.
- stall_o = is_mem & ~(state==ACCESS & `dmem_resp_i`). It is combinational.
  - It is high from the first cycle a memory op is presented through the cycle before the response.
  - It is low in the response cycle, so upstream advances at the same edge MEM/WB captures the result.
- No request is issued for a bubble, even if its control bits are set.
- Misaligned halfword and word accesses are not trapped. Alignment is defined by the rules above.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - State goes to IDLE.
  - `mem_wb_o` is all zeros and `mem_wb_valid_o`=0.
  - `dmem_read_o`, `dmem_write_o`, `dmem_mbe_o`, `dmem_address_o` and `dmem_wdata_o` are all 0.
  - `stall_o` follows its combinational equation, so it is 0 unless a valid memory op is presented.
- Non-memory instruction: 1 cycle through the stage. Back-to-back instructions run at full throughput.
- Memory instruction:
  - Request is asserted the cycle after it is presented.
  - Result lands in MEM/WB at the edge ending the response cycle.
  - Minimum occupancy is 2 cycles (response in the first ACCESS cycle). N wait states add N cycles.
- `dmem_rdata_i` is sampled only in the response cycle.
- Reset during ACCESS:
  - The request is dropped immediately and the instruction is lost.
  - A `dmem_resp_i` arriving later while in IDLE is ignored.
- `dmem_resp_i` while in IDLE is ignored and has no state change.
- Back-to-back memory ops: IDLE is re-entered after each response, so the next op issues its request one cycle later. This is 2 cycles per op minimum.

## Test plan
- ALU op, alu_out=0x1234, then a second ALU op on the next cycle -> each appears in MEM/WB 1 cycle later, valid=1, and `stall_o` stays 0.
- lw at alu_out=0x100, memory returns 0xDEADBEEF after 3 wait cycles:
  - Request address is 0x100 with read=1.
  - `stall_o` is high for 4 cycles.
  - data_mdr=0xDEADBEEF and valid=1 on the edge after the response.
- lb at 0x103 with rdata=0x80112233 -> data_mdr=0xFFFFFF80. The same with lbu -> 0x00000080.
- sh at 0x202, rs2_out=0x0000ABCD, mem_byte_enable=0011 -> address 0x200, wdata 0xABCD0000, mbe 1100, write=1. data_mdr is unchanged.
- lhu at 0x302 with rdata=0x9876_5432 -> 0x00009876. lh at 0x300 -> 0x00005432.
- Reset asserted while in ACCESS, then a response pulse after reset is released:
  - All dmem outputs drop to 0 asynchronously.
  - The late response causes no MEM/WB write.
  - The next op issues normally.

Source files
------------

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Package : rv32i_types
// Purpose : Shared RV32I pipeline bundle types and load funct3 encodings.
// Revision: 1.0 - initial release
// ============================================================================
package rv32i_types;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic       load_regfile;
    logic [4:0] rd;
    logic       dmem_read;
    logic       dmem_write;
    logic [2:0] funct3;
    logic [3:0] mem_byte_enable;
  } rv32i_ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_out;
    logic [31:0] rs2_out;
    logic [31:0] data_mdr;
  } rv32i_data_t;

  typedef struct packed {
    rv32i_ctrl_t ControlWord;
    rv32i_data_t DataWord;
  } rv32i_stage;

endpackage

// ============================================================================
// Module  : mem_stage
// Purpose : RV32I memory-access stage. Issues the data-memory request held in
//           EX/MEM, aligns store data / byte enables, extracts and extends
//           load data, and registers the bundle into MEM/WB. Stalls upstream
//           while an access is outstanding.
// Ports   : clk, rst_n (async, active-low)
//           ex_mem_i / ex_mem_valid_i      - EX/MEM bundle and valid
//           stall_o                        - freeze upstream pipeline
//           mem_wb_o / mem_wb_valid_o      - registered MEM/WB bundle
//           dmem_read_o / dmem_write_o     - registered memory request
//           dmem_address_o / dmem_wdata_o / dmem_mbe_o
//           dmem_rdata_i / dmem_resp_i     - memory response
// Revision: 1.0 - initial release
// ============================================================================
module mem_stage
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  rv32i_stage  ex_mem_i,
  input  logic        ex_mem_valid_i,
  output logic        stall_o,
  output rv32i_stage  mem_wb_o,
  output logic        mem_wb_valid_o,
  output logic        dmem_read_o,
  output logic        dmem_write_o,
  output logic [31:0] dmem_address_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_mbe_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_resp_i
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;

  logic [0:0]  r_state;
  logic [0:0]  w_state_next;

  logic        w_is_mem;
  logic        w_resp_hit;
  logic [1:0]  w_off;
  logic [31:0] w_rdata_shift;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  rv32i_stage  w_wb_done;
  logic        w_stall;

  rv32i_stage  r_mem_wb;
  logic        r_mem_wb_valid;
  logic        r_read;
  logic        r_write;
  logic [31:0] r_address;
  logic [31:0] r_wdata;
  logic [3:0]  r_mbe;

  assign w_is_mem   = ex_mem_valid_i &
                      (ex_mem_i.ControlWord.dmem_read | ex_mem_i.ControlWord.dmem_write);
  assign w_off      = ex_mem_i.DataWord.alu_out[1:0];
  assign w_resp_hit = (r_state == S_ACCESS) & dmem_resp_i;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_is_mem)    w_state_next = S_ACCESS;
      S_ACCESS: if (dmem_resp_i) w_state_next = S_IDLE;
      default:                   w_state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic: stall and load-data extraction
  // --------------------------------------------------------------------------
  always_comb begin
    // Upstream advances on the same edge that MEM/WB captures the result.
    w_stall       = w_is_mem & ~w_resp_hit;

    w_rdata_shift = dmem_rdata_i >> {w_off, 3'b000};
    // Halfword lane is picked by off[1] only; off[0] is deliberately ignored.
    w_half        = w_off[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];

    case (ex_mem_i.ControlWord.funct3)
      F3_LB:   w_load_data = {{24{w_rdata_shift[7]}}, w_rdata_shift[7:0]};
      F3_LBU:  w_load_data = {24'h000000, w_rdata_shift[7:0]};
      F3_LH:   w_load_data = {{16{w_half[15]}}, w_half};
      F3_LHU:  w_load_data = {16'h0000, w_half};
      default: w_load_data = dmem_rdata_i;
    endcase

    // r_read already encodes "read and not write", so stores keep data_mdr.
    w_wb_done = ex_mem_i;
    if (r_read) begin
      w_wb_done.DataWord.data_mdr = w_load_data;
    end
  end

  // --------------------------------------------------------------------------
  // Request and MEM/WB registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_wb       <= '0;
      r_mem_wb_valid <= 1'b0;
      r_read         <= 1'b0;
      r_write        <= 1'b0;
      r_address      <= 32'h0;
      r_wdata        <= 32'h0;
      r_mbe          <= 4'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_mem) begin
            r_mem_wb_valid <= 1'b0;
            r_address      <= {ex_mem_i.DataWord.alu_out[31:2], 2'b00};
            r_wdata        <= ex_mem_i.DataWord.rs2_out << {w_off, 3'b000};
            r_mbe          <= ex_mem_i.ControlWord.mem_byte_enable << w_off;
            r_write        <= ex_mem_i.ControlWord.dmem_write;
            r_read         <= ex_mem_i.ControlWord.dmem_read &
                              ~ex_mem_i.ControlWord.dmem_write;
          end else begin
            r_mem_wb       <= ex_mem_i;
            r_mem_wb_valid <= ex_mem_valid_i;
          end
        end
        S_ACCESS: begin
          if (dmem_resp_i) begin
            r_read         <= 1'b0;
            r_write        <= 1'b0;
            r_mbe          <= 4'h0;
            r_mem_wb       <= w_wb_done;
            r_mem_wb_valid <= 1'b1;
          end else begin
            r_mem_wb_valid <= 1'b0;
          end
        end
        default: begin
          r_mem_wb_valid <= 1'b0;
        end
      endcase
    end
  end

  assign stall_o        = w_stall;
  assign mem_wb_o       = r_mem_wb;
  assign mem_wb_valid_o = r_mem_wb_valid;
  assign dmem_read_o    = r_read;
  assign dmem_write_o   = r_write;
  assign dmem_address_o = r_address;
  assign dmem_wdata_o   = r_wdata;
  assign dmem_mbe_o     = r_mbe;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_stage
// Purpose : Self-checking bench for mem_stage. A transaction-level model
//           predicts stall, request and MEM/WB outputs for each cycle of
//           every instruction it presents; directed cases pin the model with
//           literal values, then randomized traffic exercises the rest.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_stage;
  import rv32i_types::*;

  logic        clk;
  logic        rst_n;
  rv32i_stage  ex_mem;
  logic        ex_mem_valid;
  logic        stall;
  rv32i_stage  mem_wb;
  logic        mem_wb_valid;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_mbe;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  mem_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_mem_i       (ex_mem),
    .ex_mem_valid_i (ex_mem_valid),
    .stall_o        (stall),
    .mem_wb_o       (mem_wb),
    .mem_wb_valid_o (mem_wb_valid),
    .dmem_read_o    (dmem_read),
    .dmem_write_o   (dmem_write),
    .dmem_address_o (dmem_address),
    .dmem_wdata_o   (dmem_wdata),
    .dmem_mbe_o     (dmem_mbe),
    .dmem_rdata_i   (dmem_rdata),
    .dmem_resp_i    (dmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Model of what the outputs must currently show
  rv32i_stage  exp_wb;
  logic        exp_wb_valid;
  logic        exp_read;
  logic        exp_write;
  logic [3:0]  exp_mbe;
  logic [31:0] exp_addr;
  logic [31:0] exp_wdata;
  logic        exp_stall;

  // Request outputs observed during the last response cycle, plus stall count
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_mbe;
  logic        cap_read;
  logic        cap_write;
  int          stall_cnt;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic compare_all();
    chk("stall",       {255'h0, stall},        {255'h0, exp_stall});
    chk("wb_valid",    {255'h0, mem_wb_valid}, {255'h0, exp_wb_valid});
    chk("dmem_read",   {255'h0, dmem_read},    {255'h0, exp_read});
    chk("dmem_write",  {255'h0, dmem_write},   {255'h0, exp_write});
    chk("dmem_mbe",    {252'h0, dmem_mbe},     {252'h0, exp_mbe});
    chk("dmem_addr",   {224'h0, dmem_address}, {224'h0, exp_addr});
    chk("dmem_wdata",  {224'h0, dmem_wdata},   {224'h0, exp_wdata});
    if (exp_wb_valid) chk("mem_wb", {113'h0, mem_wb}, {113'h0, exp_wb});
  endtask

  // One pipeline cycle: drive just after a rising edge, check at the falling
  // edge, return just after the next rising edge.
  task automatic drive(input rv32i_stage ins, input logic v, input logic r,
                       input logic [31:0] rd);
    ex_mem       = ins;
    ex_mem_valid = v;
    dmem_resp    = r;
    dmem_rdata   = rd;
    @(negedge clk);
    compare_all();
    if (stall) stall_cnt++;
    cap_addr  = dmem_address;
    cap_wdata = dmem_wdata;
    cap_mbe   = dmem_mbe;
    cap_read  = dmem_read;
    cap_write = dmem_write;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rdata);
    logic [31:0] b;
    logic [31:0] h;
    b = (rdata / (32'd1 << (8 * off))) % 32'd256;
    h = (rdata / (32'd1 << (16 * off[1]))) % 32'd65536;
    case (f3)
      3'b000:  return (b > 127) ? b + 32'hFFFF_FF00 : b;
      3'b100:  return b;
      3'b001:  return (h > 32767) ? h + 32'hFFFF_0000 : h;
      3'b101:  return h;
      default: return rdata;
    endcase
  endfunction

  function automatic rv32i_stage make_op(input logic rd_en, input logic wr_en,
                                         input logic [2:0] f3, input logic [3:0] be,
                                         input logic [31:0] alu, input logic [31:0] rs2,
                                         input logic [31:0] mdr);
    rv32i_stage s;
    s.ControlWord.load_regfile    = 1'($urandom_range(0, 1));
    s.ControlWord.rd              = 5'($urandom_range(0, 31));
    s.ControlWord.dmem_read       = rd_en;
    s.ControlWord.dmem_write      = wr_en;
    s.ControlWord.funct3          = f3;
    s.ControlWord.mem_byte_enable = be;
    s.DataWord.pc                 = $urandom;
    s.DataWord.alu_out            = alu;
    s.DataWord.rs2_out            = rs2;
    s.DataWord.data_mdr           = mdr;
    return s;
  endfunction

  // Present one instruction; memory ops are held for nwait wait states, then
  // answered with resp_data.
  task automatic run_op(input rv32i_stage ins, input logic v, input int nwait,
                        input logic [31:0] resp_data);
    logic       is_mem;
    logic [1:0] off;
    stall_cnt = 0;
    is_mem = v & (ins.ControlWord.dmem_read | ins.ControlWord.dmem_write);
    off    = ins.DataWord.alu_out[1:0];
    if (!is_mem) begin
      exp_stall = 1'b0;
      drive(ins, v, 1'($urandom_range(0, 1)), $urandom);
      exp_wb       = ins;
      exp_wb_valid = v;
    end else begin
      exp_stall = 1'b1;
      // A response pulse while idle must be ignored.
      drive(ins, 1'b1, 1'($urandom_range(0, 1)), $urandom);
      exp_wb_valid = 1'b0;
      exp_addr     = ins.DataWord.alu_out & 32'hFFFF_FFFC;
      exp_wdata    = ins.DataWord.rs2_out * (32'd1 << (8 * off));
      exp_mbe      = 4'((ins.ControlWord.mem_byte_enable * (8'd1 << off)) % 16);
      exp_write    = ins.ControlWord.dmem_write;
      exp_read     = ins.ControlWord.dmem_read & ~ins.ControlWord.dmem_write;
      for (int i = 0; i < nwait; i++) drive(ins, 1'b1, 1'b0, $urandom);
      exp_stall = 1'b0;
      drive(ins, 1'b1, 1'b1, resp_data);
      exp_read     = 1'b0;
      exp_write    = 1'b0;
      exp_mbe      = 4'h0;
      exp_wb       = ins;
      if (ins.ControlWord.dmem_read && !ins.ControlWord.dmem_write)
        exp_wb.DataWord.data_mdr = load_model(ins.ControlWord.funct3, off, resp_data);
      exp_wb_valid = 1'b1;
    end
  endtask

  task automatic reset_model();
    exp_wb       = '0;
    exp_wb_valid = 1'b0;
    exp_read     = 1'b0;
    exp_write    = 1'b0;
    exp_mbe      = 4'h0;
    exp_addr     = 32'h0;
    exp_wdata    = 32'h0;
    exp_stall    = 1'b0;
  endtask

  initial begin
    rv32i_stage op;
    rst_n        = 1'b0;
    ex_mem       = '0;
    ex_mem_valid = 1'b0;
    dmem_resp    = 1'b0;
    dmem_rdata   = 32'h0;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    chk("reset_wb_zero", {113'h0, mem_wb}, 256'h0);
    rst_n = 1'b1;

    // Two back-to-back ALU ops
    op = make_op(1'b0, 1'b0, 3'b000, 4'h0, 32'h1234, $urandom, $urandom);
    run_op(op, 1'b1, 0, 32'h0);
    chk("alu1_stall", {224'h0, 32'(stall_cnt)}, 256'd0);
    op = make_op(1'b0, 1'b0, 3'b000, 4'h0, 32'h5678, $urandom, $urandom);
    run_op(op, 1'b1, 0, 32'h0);
    @(negedge clk);
    chk("alu2_wb_alu", {224'h0, mem_wb.DataWord.alu_out}, {224'h0, 32'h5678});
    chk("alu2_valid", {255'h0, mem_wb_valid}, 256'd1);
    @(posedge clk);
    #1;
    exp_wb_valid = ex_mem_valid;  // ALU op 2 still presented one more cycle
    exp_wb = ex_mem;

    // lw at 0x100, 3 wait states
    op = make_op(1'b1, 1'b0, 3'b010, 4'hF, 32'h100, $urandom, 32'h0);
    run_op(op, 1'b1, 3, 32'hDEAD_BEEF);
    chk("lw_addr", {224'h0, cap_addr}, {224'h0, 32'h100});
    chk("lw_read", {255'h0, cap_read}, 256'd1);
    chk("lw_stall_cycles", {224'h0, 32'(stall_cnt)}, 256'd4);
    @(negedge clk);
    chk("lw_mdr", {224'h0, mem_wb.DataWord.data_mdr}, {224'h0, 32'hDEAD_BEEF});
    chk("lw_valid", {255'h0, mem_wb_valid}, 256'd1);
    @(posedge clk);
    #1;
    reset_model_keep(op);

    // lb / lbu at 0x103
    op = make_op(1'b1, 1'b0, 3'b000, 4'h1, 32'h103, $urandom, 32'h0);
    run_op(op, 1'b1, 1, 32'h8011_2233);
    chk("lb_mdr", {224'h0, mem_wb.DataWord.data_mdr}, {224'h0, 32'hFFFF_FF80});
    op = make_op(1'b1, 1'b0, 3'b100, 4'h1, 32'h103, $urandom, 32'h0);
    run_op(op, 1'b1, 0, 32'h8011_2233);
    chk("lbu_mdr", {224'h0, mem_wb.DataWord.data_mdr}, {224'h0, 32'h0000_0080});

    // sh at 0x202
    op = make_op(1'b0, 1'b1, 3'b001, 4'b0011, 32'h202, 32'h0000_ABCD, 32'h55AA_55AA);
    run_op(op, 1'b1, 2, $urandom);
    chk("sh_addr", {224'h0, cap_addr}, {224'h0, 32'h200});
    chk("sh_wdata", {224'h0, cap_wdata}, {224'h0, 32'hABCD_0000});
    chk("sh_mbe", {252'h0, cap_mbe}, {252'h0, 4'b1100});
    chk("sh_write", {255'h0, cap_write}, 256'd1);
    chk("sh_mdr", {224'h0, mem_wb.DataWord.data_mdr}, {224'h0, 32'h55AA_55AA});

    // lhu at 0x302, lh at 0x300
    op = make_op(1'b1, 1'b0, 3'b101, 4'h3, 32'h302, $urandom, 32'h0);
    run_op(op, 1'b1, 0, 32'h9876_5432);
    chk("lhu_mdr", {224'h0, mem_wb.DataWord.data_mdr}, {224'h0, 32'h0000_9876});
    op = make_op(1'b1, 1'b0, 3'b001, 4'h3, 32'h300, $urandom, 32'h0);
    run_op(op, 1'b1, 0, 32'h9876_5432);
    chk("lh_mdr", {224'h0, mem_wb.DataWord.data_mdr}, {224'h0, 32'h0000_5432});

    // Reset while in ACCESS, then a late response
    op = make_op(1'b1, 1'b0, 3'b010, 4'hF, 32'h400, $urandom, 32'h0);
    exp_stall = 1'b1;
    drive(op, 1'b1, 1'b0, $urandom);
    exp_wb_valid = 1'b0;
    exp_addr     = 32'h400;
    exp_wdata    = op.DataWord.rs2_out;
    exp_mbe      = 4'hF;
    exp_read     = 1'b1;
    exp_write    = 1'b0;
    drive(op, 1'b1, 1'b0, $urandom);
    #2;
    rst_n        = 1'b0;
    ex_mem_valid = 1'b0;
    #1;
    chk("rst_read", {255'h0, dmem_read}, 256'd0);
    chk("rst_mbe", {252'h0, dmem_mbe}, 256'd0);
    chk("rst_addr", {224'h0, dmem_address}, 256'd0);
    chk("rst_wdata", {224'h0, dmem_wdata}, 256'd0);
    chk("rst_wb_valid", {255'h0, mem_wb_valid}, 256'd0);
    chk("rst_stall", {255'h0, stall}, 256'd0);
    reset_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_op(op, 1'b0, 0, $urandom);
    dmem_resp = 1'b0;
    chk("late_resp_valid", {255'h0, mem_wb_valid}, 256'd0);
    chk("late_resp_read", {255'h0, dmem_read}, 256'd0);
    op = make_op(1'b1, 1'b0, 3'b010, 4'hF, 32'h500, $urandom, 32'h0);
    run_op(op, 1'b1, 1, 32'h1357_9BDF);
    chk("post_rst_mdr", {224'h0, mem_wb.DataWord.data_mdr}, {224'h0, 32'h1357_9BDF});

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      logic [31:0] kind;
      kind = $urandom_range(0, 9);
      op = make_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                   $urandom, $urandom, $urandom);
      if (kind < 3) begin
        op.ControlWord.dmem_read  = 1'b0;
        op.ControlWord.dmem_write = 1'b0;
      end
      run_op(op, (kind != 9), $urandom_range(0, 4), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // After a directed op that was sampled one extra cycle, the same
  // instruction was still presented: it is a memory op, so that cycle
  // started a fresh access. Finish that access before moving on.
  task automatic reset_model_keep(input rv32i_stage ins);
    logic [1:0] off;
    off          = ins.DataWord.alu_out[1:0];
    exp_wb_valid = 1'b0;
    exp_addr     = ins.DataWord.alu_out & 32'hFFFF_FFFC;
    exp_wdata    = ins.DataWord.rs2_out * (32'd1 << (8 * off));
    exp_mbe      = 4'((ins.ControlWord.mem_byte_enable * (8'd1 << off)) % 16);
    exp_write    = 1'b0;
    exp_read     = 1'b1;
    exp_stall    = 1'b0;
    drive(ins, 1'b1, 1'b1, 32'hDEAD_BEEF);
    exp_read     = 1'b0;
    exp_mbe      = 4'h0;
    exp_wb       = ins;
    exp_wb.DataWord.data_mdr = 32'hDEAD_BEEF;
    exp_wb_valid = 1'b1;
  endtask

endmodule
`default_nettype wire
